// File: rtl/xgemac_wb_stat_int.sv
// Wishbone management slave for the XGE MAC: CONFIG, interrupt pending/status/mask
// and saturating packet statistics counters behind a single-cycle ack handshake.
module xgemac_wb_stat_int #(
   parameter int N_INT   = 8,
   parameter int CNT_W   = 32,
   parameter bit CFG_RST = 1'b1
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [7:0]       wb_adr_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [31:0]      wb_dat_i,
   output logic [31:0]      wb_dat_o,
   output logic             wb_ack_o,
   output logic             wb_int_o,
   input  logic [N_INT-1:0] int_evt_i,
   input  logic             tx_pkt_i,
   input  logic             rx_pkt_i,
   input  logic             rx_err_i,
   output logic             tx_enable_o
);

   localparam logic [5:0] ADR_CONFIG  = 6'h00;
   localparam logic [5:0] ADR_PENDING = 6'h02;
   localparam logic [5:0] ADR_STATUS  = 6'h03;
   localparam logic [5:0] ADR_MASK    = 6'h04;
   localparam logic [5:0] ADR_TXCNT   = 6'h08;
   localparam logic [5:0] ADR_RXCNT   = 6'h09;
   localparam logic [5:0] ADR_ERRCNT  = 6'h0A;

   logic             r_ack;
   logic [31:0]      r_datO;
   logic             r_int;
   logic             r_txEnable;
   logic [N_INT-1:0] r_pending;
   logic [N_INT-1:0] r_intStatus;
   logic [N_INT-1:0] r_intMask;
   logic [CNT_W-1:0] r_txPktCnt;
   logic [CNT_W-1:0] r_rxPktCnt;
   logic [CNT_W-1:0] r_rxErrCnt;

   logic             w_access;
   logic             w_wr;
   logic             w_rd;
   logic [5:0]       w_wordAdr;
   logic [31:0]      w_rdData;
   logic [N_INT-1:0] w_pendClr;
   logic             w_unused;

   // Side effects are committed on the edge that raises ack, so the read data and
   // the clear see the same pending snapshot and no event can slip between them.
   assign w_access  = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_wr      = w_access & wb_we_i;
   assign w_rd      = w_access & ~wb_we_i;
   assign w_wordAdr = wb_adr_i[7:2];
   assign w_pendClr = {N_INT{w_rd && (w_wordAdr == ADR_PENDING)}};
   assign w_unused  = &{1'b0, wb_dat_i, wb_adr_i[1:0]};

   assign wb_ack_o    = r_ack;
   assign wb_dat_o    = r_datO;
   assign wb_int_o    = r_int;
   assign tx_enable_o = r_txEnable;

   function automatic logic [CNT_W-1:0] nextCnt(input logic [CNT_W-1:0] cnt,
                                                input logic clr, input logic pulse);
      if (clr)
         return CNT_W'(pulse);
      else if (&cnt)
         return cnt;
      else
         return cnt + CNT_W'(pulse);
   endfunction

   always_comb begin
      w_rdData = '0;
      case (w_wordAdr)
         ADR_CONFIG:  w_rdData[0]         = r_txEnable;
         ADR_PENDING: w_rdData[N_INT-1:0] = r_pending;
         ADR_STATUS:  w_rdData[N_INT-1:0] = r_intStatus;
         ADR_MASK:    w_rdData[N_INT-1:0] = r_intMask;
         ADR_TXCNT:   w_rdData[CNT_W-1:0] = r_txPktCnt;
         ADR_RXCNT:   w_rdData[CNT_W-1:0] = r_rxPktCnt;
         ADR_ERRCNT:  w_rdData[CNT_W-1:0] = r_rxErrCnt;
         default:     w_rdData            = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack       <= 1'b0;
         r_datO      <= '0;
         r_int       <= 1'b0;
         r_txEnable  <= CFG_RST;
         r_pending   <= '0;
         r_intStatus <= '0;
         r_intMask   <= '0;
         r_txPktCnt  <= '0;
         r_rxPktCnt  <= '0;
         r_rxErrCnt  <= '0;
      end else begin
         r_ack       <= w_access;
         r_datO      <= w_rd ? w_rdData : '0;
         r_pending   <= (r_pending & ~w_pendClr) | int_evt_i;
         r_intStatus <= int_evt_i;
         r_int       <= |(r_pending & r_intMask);
         if (w_wr && (w_wordAdr == ADR_CONFIG))
            r_txEnable <= wb_dat_i[0];
         if (w_wr && (w_wordAdr == ADR_MASK))
            r_intMask <= wb_dat_i[N_INT-1:0];
         r_txPktCnt <= nextCnt(r_txPktCnt, w_wr && (w_wordAdr == ADR_TXCNT), tx_pkt_i);
         r_rxPktCnt <= nextCnt(r_rxPktCnt, w_wr && (w_wordAdr == ADR_RXCNT), rx_pkt_i);
         r_rxErrCnt <= nextCnt(r_rxErrCnt, w_wr && (w_wordAdr == ADR_ERRCNT), rx_err_i);
      end
   end

endmodule

// File: tb/tb_xgemac_wb_stat_int.sv
// Directed bench for xgemac_wb_stat_int: bus handshake, interrupt pending/mask path,
// saturating counters (CNT_W=4) and reset behaviour, with hand-computed expectations.
module tb_xgemac_wb_stat_int;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  adr;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] datI;
   logic [31:0] datO;
   logic        ack;
   logic        intO;
   logic [7:0]  intEvt;
   logic        txPkt;
   logic        rxPkt;
   logic        rxErr;
   logic        txEnable;

   int checks = 0;
   int errors = 0;
   logic [31:0] rdData;

   xgemac_wb_stat_int #(.N_INT(8), .CNT_W(4), .CFG_RST(1'b1)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wb_adr_i   (adr),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_dat_i   (datI),
      .wb_dat_o   (datO),
      .wb_ack_o   (ack),
      .wb_int_o   (intO),
      .int_evt_i  (intEvt),
      .tx_pkt_i   (txPkt),
      .rx_pkt_i   (rxPkt),
      .rx_err_i   (rxErr),
      .tx_enable_o(txEnable)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One bus transfer; returns #1 after the idle edge that follows the ack.
   task automatic applyStimulus(input string tag, input logic isWrite, input logic [7:0] a,
                                input logic [31:0] wdat, output logic [31:0] rdat);
      cyc  = 1'b1;
      stb  = 1'b1;
      we   = isWrite;
      adr  = a;
      datI = wdat;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4 && !ack; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput({tag, "_ack"}, {31'd0, ack}, 32'd1);
      rdat = datO;
      cyc  = 1'b0;
      stb  = 1'b0;
      we   = 1'b0;
      datI = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; datI = '0;
      intEvt = '0; txPkt = 1'b0; rxPkt = 1'b0; rxErr = 1'b0;

      // Reset state
      tick(2);
      rst = 1'b0;
      checkOutput("rst_ack", {31'd0, ack}, 32'd0);
      checkOutput("rst_int", {31'd0, intO}, 32'd0);
      checkOutput("rst_dat", datO, 32'd0);
      checkOutput("rst_txen", {31'd0, txEnable}, 32'd1);
      applyStimulus("rd_cfg0", 1'b0, 8'h00, '0, rdData);
      checkOutput("rd_cfg0_dat", rdData, 32'h1);
      applyStimulus("rd_mask0", 1'b0, 8'h10, '0, rdData);
      checkOutput("rd_mask0_dat", rdData, 32'h0);
      applyStimulus("rd_tx0", 1'b0, 8'h20, '0, rdData);
      checkOutput("rd_tx0_dat", rdData, 32'h0);

      // CONFIG write/readback, upper bits read 0
      applyStimulus("wr_cfg", 1'b1, 8'h00, 32'hFFFF_FFFE, rdData);
      checkOutput("txen_off", {31'd0, txEnable}, 32'd0);
      applyStimulus("rd_cfg1", 1'b0, 8'h00, '0, rdData);
      checkOutput("rd_cfg1_dat", rdData, 32'h0);
      applyStimulus("wr_cfg2", 1'b1, 8'h03, 32'h0000_0003, rdData);
      applyStimulus("rd_cfg2", 1'b0, 8'h00, '0, rdData);
      checkOutput("rd_cfg2_dat", rdData, 32'h1);

      // Interrupt latency and clear-on-read
      applyStimulus("wr_mask", 1'b1, 8'h10, 32'h0000_01FF, rdData);
      applyStimulus("rd_mask", 1'b0, 8'h10, '0, rdData);
      checkOutput("rd_mask_dat", rdData, 32'hFF);
      intEvt = 8'h04;
      tick(1);
      intEvt = '0;
      checkOutput("int_n1", {31'd0, intO}, 32'd0);
      tick(1);
      checkOutput("int_n2", {31'd0, intO}, 32'd1);
      applyStimulus("rd_pend1", 1'b0, 8'h08, '0, rdData);
      checkOutput("rd_pend1_dat", rdData, 32'h04);
      checkOutput("int_cleared", {31'd0, intO}, 32'd0);
      applyStimulus("rd_pend2", 1'b0, 8'h08, '0, rdData);
      checkOutput("rd_pend2_dat", rdData, 32'h00);

      // Event coincident with the clearing read: set wins, read shows old value
      intEvt = 8'h04;
      tick(1);
      intEvt = '0;
      tick(1);
      checkOutput("int_again", {31'd0, intO}, 32'd1);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h08; intEvt = 8'h04;
      tick(1);
      intEvt = '0;
      checkOutput("race_ack", {31'd0, ack}, 32'd1);
      checkOutput("race_dat", datO, 32'h04);
      cyc = 1'b0; stb = 1'b0;
      tick(1);
      checkOutput("race_int1", {31'd0, intO}, 32'd1);
      tick(1);
      checkOutput("race_int2", {31'd0, intO}, 32'd1);
      applyStimulus("rd_pend3", 1'b0, 8'h08, '0, rdData);
      checkOutput("rd_pend3_dat", rdData, 32'h04);

      // INT_STATUS mirrors the previous cycle's events
      intEvt = 8'h81;
      tick(1);
      intEvt = '0;
      applyStimulus("rd_stat", 1'b0, 8'h0C, '0, rdData);
      checkOutput("rd_stat_dat", rdData, 32'h81);
      applyStimulus("rd_pend4", 1'b0, 8'h08, '0, rdData);
      checkOutput("rd_pend4_dat", rdData, 32'h81);

      // Saturating counters, clear with a coincident pulse
      txPkt = 1'b1;
      tick(20);
      txPkt = 1'b0;
      applyStimulus("rd_txsat", 1'b0, 8'h20, '0, rdData);
      checkOutput("rd_txsat_dat", rdData, 32'hF);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h20; datI = 32'hDEAD_BEEF; txPkt = 1'b1;
      tick(1);
      txPkt = 1'b0;
      checkOutput("wr_tx_ack", {31'd0, ack}, 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; datI = '0;
      tick(1);
      applyStimulus("rd_tx1", 1'b0, 8'h20, '0, rdData);
      checkOutput("rd_tx1_dat", rdData, 32'h1);
      rxPkt = 1'b1;
      tick(3);
      rxPkt = 1'b0;
      rxErr = 1'b1;
      tick(1);
      rxErr = 1'b0;
      applyStimulus("rd_rx", 1'b0, 8'h24, '0, rdData);
      checkOutput("rd_rx_dat", rdData, 32'h3);
      applyStimulus("rd_err", 1'b0, 8'h28, '0, rdData);
      checkOutput("rd_err_dat", rdData, 32'h1);
      applyStimulus("wr_rx", 1'b1, 8'h24, 32'h0, rdData);
      applyStimulus("rd_rx0", 1'b0, 8'h24, '0, rdData);
      checkOutput("rd_rx0_dat", rdData, 32'h0);

      // Held strobe on an unmapped address: ack toggles, data stays 0
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'hFC;
      #1;
      checkOutput("held_ack0", {31'd0, ack}, 32'd0);
      tick(1);
      checkOutput("held_ack1", {31'd0, ack}, 32'd1);
      checkOutput("held_dat1", datO, 32'h0);
      tick(1);
      checkOutput("held_ack2", {31'd0, ack}, 32'd0);
      tick(1);
      checkOutput("held_ack3", {31'd0, ack}, 32'd1);
      checkOutput("held_dat3", datO, 32'h0);
      cyc = 1'b0; stb = 1'b0;
      tick(1);

      // Reset overlapping a strobe: no ack, registers back to reset values
      applyStimulus("wr_cfg3", 1'b1, 8'h00, 32'h0, rdData);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10; rst = 1'b1;
      tick(1);
      checkOutput("rststb_ack1", {31'd0, ack}, 32'd0);
      tick(1);
      checkOutput("rststb_ack2", {31'd0, ack}, 32'd0);
      cyc = 1'b0; stb = 1'b0; rst = 1'b0;
      tick(1);
      checkOutput("rststb_ack3", {31'd0, ack}, 32'd0);
      checkOutput("rststb_txen", {31'd0, txEnable}, 32'd1);
      applyStimulus("rd_mask_rst", 1'b0, 8'h10, '0, rdData);
      checkOutput("rd_mask_rst_dat", rdData, 32'h0);
      applyStimulus("rd_tx_rst", 1'b0, 8'h20, '0, rdData);
      checkOutput("rd_tx_rst_dat", rdData, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
